// File: rtl/flopr_pipe.sv
// flopr_pipe: STAGES-deep valid/ready register chain, N bits wide; STAGES cycles latency, bubbles collapse, ready passes through combinationally.
// Optional FLOPR_PIPE_OCC_EN adds a registered occupancy count; flush clears all valid bits synchronously.
module flopr_pipe #(
   parameter int N      = 64,
   parameter int STAGES = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
`ifdef FLOPR_PIPE_OCC_EN
   ,
   output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

   logic [STAGES-1:0] valid;
   logic [N-1:0]      data [STAGES];
   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] up_valid;
   logic [N-1:0]      up_data [STAGES];

   // rdy[i] is high unless every stage from i to the output is full and the
   // sink is stalled; built from valid directly to keep the chain acyclic.
   always_comb begin
      logic full_acc;
      full_acc = 1'b1;
      rdy      = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         full_acc = full_acc & valid[i];
         rdy[i]   = !full_acc || out_ready;
      end
   end

   always_comb begin
      up_valid[0] = in_valid;
      up_data[0]  = in_data;
      for (int i = 1; i < STAGES; i++) begin
         up_valid[i] = valid[i-1];
         up_data[i]  = data[i-1];
      end
   end

   assign in_ready  = rdy[0] && !flush;
   assign out_valid = valid[STAGES-1];
   assign out_data  = data[STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
         for (int i = 0; i < STAGES; i++) data[i] <= '0;
      end else if (flush) begin
         valid <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (rdy[i]) begin
               valid[i] <= up_valid[i];
               // Data only moves with a valid word, so bubbles cause no toggling.
               if (up_valid[i]) data[i] <= up_data[i];
            end
         end
      end
   end

`ifdef FLOPR_PIPE_OCC_EN
   logic [$clog2(STAGES+1)-1:0] occ;
   logic                        in_xfer;
   logic                        out_xfer;

   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign occupancy = occ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      occ <= '0;
      else if (flush)                  occ <= '0;
      else if (in_xfer && !out_xfer)   occ <= occ + 1'b1;
      else if (out_xfer && !in_xfer)   occ <= occ - 1'b1;
   end

   occ_matches_valid: assert property (@(posedge clk) disable iff (!reset)
      32'(occ) == $countones(valid));
`endif

endmodule

// File: tb/tb_flopr_pipe.sv
// Directed scoreboard bench for flopr_pipe (N=64, STAGES=3); occupancy checked when FLOPR_PIPE_OCC_EN is defined.
module tb_flopr_pipe;
   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
`ifdef FLOPR_PIPE_OCC_EN
   logic [1:0]  occupancy;
`endif

   int checks = 0;
   int errors = 0;
   int nout   = 0;
   int base;
   logic [63:0] sb [$];

   always #5 clk = ~clk;

   flopr_pipe #(.N(64), .STAGES(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef FLOPR_PIPE_OCC_EN
      ,
      .occupancy (occupancy)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_occ(input string tag, input logic [63:0] exp);
`ifdef FLOPR_PIPE_OCC_EN
      chk(tag, 64'(occupancy), exp);
`endif
   endtask

   // Samples the handshake before the edge, updates the scoreboard, then advances one clock.
   task automatic tick();
      logic [63:0] e;
      #1;
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
         nout++;
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected: got %0h expected no output", out_data);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_data", out_data, e);
         end
      end
      if (flush) sb.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (sb.size() != 0 && n < maxc) begin
         tick();
         n++;
      end
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL drain_timeout: got %0d words left expected 0", sb.size());
      end
   endtask

   initial begin
      // Reset held with a word offered at the input
      reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 64'd5;
      #50;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_in_ready",  in_ready,  1);
      chk_occ("rst_occ", 0);
      reset = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("lat_not_early", out_valid, 0);
      tick();
      chk("lat_out_valid", out_valid, 1);
      chk("lat_out_data",  out_data,  64'd5);
      drain(5);

      // Streaming 0..9 at full rate
      base = nout;
      for (int v = 0; v < 10; v++) begin
         in_valid = 1'b1; in_data = 64'(v);
         tick();
      end
      in_valid = 1'b0;
      chk("stream_first7", 64'(nout - base), 7);
      tick(); tick(); tick();
      chk("stream_all10", 64'(nout - base), 10);
      chk("stream_empty", out_valid, 0);

      // Stall and fill
      out_ready = 1'b0;
      for (int v = 1; v <= 3; v++) begin
         in_valid = 1'b1; in_data = 64'(v);
         tick();
      end
      in_data = 64'd4;
      #1;
      chk("full_in_ready", in_ready, 0);
      chk("full_out_data", out_data, 64'd1);
      chk_occ("full_occ", 3);
      tick();
      chk("full_hold", out_data, 64'd1);
      base = nout;
      out_ready = 1'b1;
      #1;
      chk("ready_passthru", in_ready, 1);
      tick();
      in_valid = 1'b0;
      drain(8);
      chk("fill_count", 64'(nout - base), 4);

      // Bubble collapse
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'd7; tick();
      in_valid = 1'b0; tick(); tick();
      in_valid = 1'b1; in_data = 64'd8; tick();
      in_valid = 1'b0; tick(); tick();
      chk("bub_out_data", out_data, 64'd7);
      chk("bub_out_valid", out_valid, 1);
      chk("bub_in_ready", in_ready, 1);
      chk_occ("bub_occ", 2);
      base = nout;
      out_ready = 1'b1;
      tick();
      chk("bub_first", 64'(nout - base), 1);
      tick();
      chk("bub_second", 64'(nout - base), 2);
      chk("bub_empty", out_valid, 0);

      // Flush with a full pipe and a word offered
      out_ready = 1'b0;
      for (int v = 10; v <= 12; v++) begin
         in_valid = 1'b1; in_data = 64'(v);
         tick();
      end
      in_data = 64'd13; flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      chk("flush_out_valid", out_valid, 1);
      chk("flush_out_data", out_data, 64'd10);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("post_flush_valid", out_valid, 0);
      chk_occ("post_flush_occ", 0);
      out_ready = 1'b1;
      base = nout;
      for (int c = 0; c < 5; c++) tick();
      chk("flush_no_out", 64'(nout - base), 0);

      // Asynchronous reset mid-operation
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'd20; tick();
      in_valid = 1'b0; tick();
      in_valid = 1'b1; in_data = 64'd21; tick();
      in_valid = 1'b0;
      chk("pre_arst_valid", out_valid, 1);
      chk("pre_arst_data", out_data, 64'd20);
      chk_occ("pre_arst_occ", 2);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 0);
      chk_occ("arst_occ", 0);
      sb.delete();
      #1;
      reset = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      base = nout;
      in_valid = 1'b1; in_data = 64'd30; tick();
      in_data = 64'd31; tick();
      in_valid = 1'b0;
      tick();
      chk("after_arst_data", out_data, 64'd30);
      drain(6);
      chk("after_arst_count", 64'(nout - base), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
